mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/mux_arb_n.sv | 97 +++++++++
 tb/tb_mux_arb_n.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the N-to-1 arbitrated mux.
// Contents:
//   mode_e : arbitration mode encoding carried on the 2-bit mode port.
package mux_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'b00,   // lowest index wins
      MODE_RR    = 2'b01,   // rotating priority starting at ptr
      MODE_FORCE = 2'b10,   // only channel sel may be granted
      MODE_RSVD  = 2'b11    // no grants
   } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational one-hot grant generator.
// Ports:
//   req   [N-1:0]  in  per-channel request
//   ptr   [SW-1:0] in  round-robin start index
//   mode  [1:0]    in  arbitration mode (mux_pkg::mode_e)
//   sel   [SW-1:0] in  forced-select channel index
//   grant [N-1:0]  out one-hot (or zero) grant
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic [1:0]    mode,
   input  logic [SW-1:0] sel,
   output logic [N-1:0]  grant
);

   localparam logic [N-1:0] L_ONE = {{(N-1){1'b0}}, 1'b1};

   // Isolates the lowest set bit (two's-complement trick).
   function automatic logic [N-1:0] f_lowest(input logic [N-1:0] x);
      return x & (~x + L_ONE);
   endfunction

   logic [N-1:0] w_hi_mask;
   logic [N-1:0] w_req_hi;

   // Bits at or above ptr; scanning these first, then wrapping to the
   // full request vector, gives the ptr-upward circular search.
   always_comb begin
      w_hi_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_hi_mask[i] = (i >= int'(ptr));
      end
   end

   assign w_req_hi = req & w_hi_mask;

   always_comb begin
      grant = '0;
      case (mode_e'(mode))
         MODE_FIXED: grant = f_lowest(req);
         MODE_RR:    grant = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(req);
         MODE_FORCE: begin
            // sel values beyond N-1 match no channel and grant nothing.
            for (int i = 0; i < N; i++) begin
               grant[i] = req[i] & (int'(sel) == i);
            end
         end
         default:    grant = '0;
      endcase
   end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n
// N-channel arbitrated mux with a single registered output stage.
// Ports:
//   clk                in  clock, rising edge
//   resetn             in  synchronous active-low reset
//   src_valid [N-1:0]  in  per-channel request
//   src_data  [N*W-1:0] in packed channel data, channel i at [i*W +: W]
//   src_ready [N-1:0]  out per-channel accept (at most one set)
//   mode      [1:0]    in  arbitration mode
//   sel       [SW-1:0] in  forced-select channel
//   out_valid          out output stage holds a beat
//   out_data  [W-1:0]  out registered beat data
//   out_idx   [SW-1:0] out source channel of the beat
//   out_ready          in  downstream accept
module mux_arb_n
   import mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [N-1:0]   src_valid,
   input  logic [N*W-1:0] src_data,
   output logic [N-1:0]   src_ready,
   input  logic [1:0]     mode,
   input  logic [SW-1:0]  sel,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_idx,
   input  logic           out_ready
);

   localparam logic [SW-1:0] L_LAST = SW'(N - 1);

   logic          r_out_valid;
   logic [W-1:0]  r_out_data;
   logic [SW-1:0] r_out_idx;
   logic [SW-1:0] r_ptr;

   logic          w_load_en;
   logic [N-1:0]  w_grant;
   logic          w_hs;
   logic [W-1:0]  w_sel_data;
   logic [SW-1:0] w_sel_idx;

   rr_arbiter #(
      .N  (N),
      .SW (SW)
   ) u_arb (
      .req   (src_valid),
      .ptr   (r_ptr),
      .mode  (mode),
      .sel   (sel),
      .grant (w_grant)
   );

   assign w_load_en = ~r_out_valid | out_ready;
   // Gating with resetn keeps sources from seeing an accept that the
   // reset edge would then discard.
   assign src_ready = w_grant & {N{w_load_en & resetn}};
   assign w_hs      = |(src_ready & src_valid);

   // Grant is one-hot, so a plain AND-OR selects data and index.
   always_comb begin
      w_sel_data = '0;
      w_sel_idx  = '0;
      for (int i = 0; i < N; i++) begin
         w_sel_data = w_sel_data | (src_data[i*W +: W] & {W{w_grant[i]}});
         w_sel_idx  = w_sel_idx  | (SW'(i) & {SW{w_grant[i]}});
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_ptr       <= '0;
      end else if (w_load_en) begin
         if (w_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_idx   <= w_sel_idx;
            r_ptr       <= (w_sel_idx == L_LAST) ? '0 : w_sel_idx + SW'(1);
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;

   logic         clk = 1'b0;
   logic         resetn;
   // N=4, W=32 instance
   logic [3:0]   src_valid;
   logic [127:0] src_data;
   logic [3:0]   src_ready;
   logic [1:0]   mode;
   logic [1:0]   sel;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [1:0]   out_idx;
   logic         out_ready;
   // N=8, W=8 instance
   logic [7:0]   b_src_valid;
   logic [63:0]  b_src_data;
   logic [7:0]   b_src_ready;
   logic [1:0]   b_mode;
   logic [2:0]   b_sel;
   logic         b_out_valid;
   logic [7:0]   b_out_data;
   logic [2:0]   b_out_idx;
   logic         b_out_ready;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mux_arb_n #(.N(4), .W(32)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .mode      (mode),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_ready (out_ready)
   );

   mux_arb_n #(.N(8), .W(8)) u_dut8 (
      .clk       (clk),
      .resetn    (resetn),
      .src_valid (b_src_valid),
      .src_data  (b_src_data),
      .src_ready (b_src_ready),
      .mode      (b_mode),
      .sel       (b_sel),
      .out_valid (b_out_valid),
      .out_data  (b_out_data),
      .out_idx   (b_out_idx),
      .out_ready (b_out_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn      = 1'b0;
      src_valid   = 4'hF;
      src_data    = {32'h33333333, 32'h22222222, 32'h11111111, 32'hA0A0A0A0};
      mode        = 2'b00;
      sel         = 2'd0;
      out_ready   = 1'b1;
      b_src_valid = 8'h00;
      b_src_data  = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h0F};
      b_mode      = 2'b10;
      b_sel       = 3'd0;
      b_out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data, 0);
      check("rst_idx",   out_idx, 0);
      check("rst_ready", src_ready, 4'b0000);

      // Fixed priority: lowest of 1010 is ch1
      resetn = 1'b1; src_valid = 4'b1010;
      #1 check("fix_ready", src_ready, 4'b0010);
      tick();
      check("fix_valid", out_valid, 1);
      check("fix_data",  out_data, 32'h11111111);
      check("fix_idx",   out_idx, 1);
      // No requests: drains and clears
      src_valid = 4'b0000;
      tick();
      check("drain_valid", out_valid, 0);

      // Round-robin from a fresh ptr=0, all requesting
      resetn = 1'b0;
      tick();
      resetn = 1'b1; mode = 2'b01; src_valid = 4'hF;
      tick(); check("rr0_idx", out_idx, 0); check("rr0_data", out_data, 32'hA0A0A0A0);
      tick(); check("rr1_idx", out_idx, 1); check("rr1_valid", out_valid, 1);
      tick(); check("rr2_idx", out_idx, 2); check("rr2_data", out_data, 32'h22222222);
      tick(); check("rr3_idx", out_idx, 3); check("rr3_valid", out_valid, 1);
      tick(); check("rr4_idx", out_idx, 0); check("rr4_valid", out_valid, 1);

      // Stall 3 cycles holding ch0 beat; ptr now 1
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 check("stall_ready", src_ready, 4'b0000);
         tick();
         check("stall_data", out_data, 32'hA0A0A0A0);
         check("stall_idx",  out_idx, 0);
      end
      out_ready = 1'b1;
      #1 check("unstall_ready", src_ready, 4'b0010);
      tick();
      check("unstall_idx",  out_idx, 1);
      check("unstall_data", out_data, 32'h11111111);

      // Reset mid-stall: ptr was 2 after ch1 handshake
      out_ready = 1'b0;
      tick();
      resetn = 1'b0;
      tick();
      check("mrst_valid", out_valid, 0);
      check("mrst_idx",   out_idx, 0);
      check("mrst_data",  out_data, 0);
      resetn = 1'b1; out_ready = 1'b1;
      #1 check("mrst_ready", src_ready, 4'b0001);
      tick();
      check("mrst_first", out_idx, 0);

      // Reserved mode while holding ch0 beat; ptr is 1
      mode = 2'b11; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 check("rsvd_ready", src_ready, 4'b0000);
         tick();
         check("rsvd_hold", out_idx, 0);
      end
      out_ready = 1'b1;
      #1 check("rsvd_ready_lo", src_ready, 4'b0000);
      tick();
      check("rsvd_drain", out_valid, 0);
      mode = 2'b01;
      #1 check("rsvd_ptr", src_ready, 4'b0010);
      tick();
      check("rsvd_next", out_idx, 1);

      // Forced select
      mode = 2'b10; sel = 2'd2; src_valid = 4'b0100;
      #1 check("frc_ready", src_ready, 4'b0100);
      tick();
      check("frc_idx",  out_idx, 2);
      check("frc_data", out_data, 32'h22222222);
      sel = 2'd3; src_valid = 4'b0111;
      #1 check("frc_none", src_ready, 4'b0000);
      tick();
      check("frc_clear", out_valid, 0);
      // Mode change takes effect in the same cycle
      mode = 2'b00; src_valid = 4'b1100;
      #1 check("mode_chg", src_ready, 4'b0100);

      // N=8: forced select including sel=5
      b_sel = 3'd0; b_src_valid = 8'h01;
      #1 check("b_ready0", b_src_ready, 8'h01);
      tick();
      check("b_idx0", b_out_idx, 0);
      check("b_data0", b_out_data, 8'h0F);
      b_sel = 3'd5; b_src_valid = 8'hDF;
      #1 check("b_none", b_src_ready, 8'h00);
      tick();
      check("b_clear", b_out_valid, 0);
      b_src_valid = 8'h20;
      #1 check("b_ready5", b_src_ready, 8'h20);
      tick();
      check("b_idx5",  b_out_idx, 5);
      check("b_data5", b_out_data, 8'h55);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
